// File: rtl/ibex_noc_endpoint_if.sv
// ibex_noc_endpoint_if
// Bundles the core-side send/deliver signals and the two flit channels of a
// NoC endpoint. Signal names keep the endpoint's view (_i = into the
// endpoint, _o = out of the endpoint).
//   slave  : the endpoint itself
//   master : the core plus the network (the testbench drives this side)
interface ibex_noc_endpoint_if;
  // Core send side
  logic        core_req_i;
  logic        core_gnt_o;
  logic        core_valid_i;
  logic [1:0]  core_len_i;
  logic [31:0] core_data_i;
  logic [15:0] core_addr_i;
  logic [15:0] core_dest_i;
  logic [31:0] core_msg1_i;
  logic [31:0] core_msg2_i;
  logic [31:0] core_msg3_i;
  // Core delivery side
  logic        deliv_valid_o;
  logic [1:0]  deliv_len_o;
  logic [31:0] deliv_data_o;
  logic [15:0] deliv_addr_o;
  logic [31:0] deliv_msg1_o;
  logic [31:0] deliv_msg2_o;
  logic [31:0] deliv_msg3_o;
  // Network flit channels
  logic        tx_flit_valid_o;
  logic        tx_flit_ready_i;
  logic [33:0] tx_flit_o;
  logic        rx_flit_valid_i;
  logic        rx_flit_ready_o;
  logic [33:0] rx_flit_i;
  logic [7:0]  drop_cnt_o;

  modport slave (
    input  core_req_i, core_valid_i, core_len_i, core_data_i, core_addr_i,
           core_dest_i, core_msg1_i, core_msg2_i, core_msg3_i,
           tx_flit_ready_i, rx_flit_valid_i, rx_flit_i,
    output core_gnt_o, deliv_valid_o, deliv_len_o, deliv_data_o, deliv_addr_o,
           deliv_msg1_o, deliv_msg2_o, deliv_msg3_o,
           tx_flit_valid_o, tx_flit_o, rx_flit_ready_o, drop_cnt_o
  );

  modport master (
    output core_req_i, core_valid_i, core_len_i, core_data_i, core_addr_i,
           core_dest_i, core_msg1_i, core_msg2_i, core_msg3_i,
           tx_flit_ready_i, rx_flit_valid_i, rx_flit_i,
    input  core_gnt_o, deliv_valid_o, deliv_len_o, deliv_data_o, deliv_addr_o,
           deliv_msg1_o, deliv_msg2_o, deliv_msg3_o,
           tx_flit_valid_o, tx_flit_o, rx_flit_ready_o, drop_cnt_o
  );
endinterface

// File: rtl/ibex_noc_endpoint.sv
// ibex_noc_endpoint
// Serialises core messages into 34-bit flits (header, data, 0..3 extra words)
// and reassembles inbound flits into one-cycle delivery pulses. Inbound
// messages addressed to another core are optionally discarded and counted.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   core_id_i     : this endpoint's core number (quasi-static)
//   bus           : core send/deliver signals and tx/rx flit channels
// Flit format: header = {len, dest[15:0], addr[15:0]}; others = {2'b00, word}.
module ibex_noc_endpoint #(
  parameter logic DropForeign = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [15:0]          core_id_i,
  ibex_noc_endpoint_if.slave   bus
);

  // ---------------------------------------------------------------- TX path
  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_DATA, TX_MSG} tx_state_e;

  tx_state_e   tx_state_q, tx_state_d;
  logic [1:0]  tx_len_q, tx_idx_q;
  logic [15:0] tx_dest_q, tx_addr_q;
  logic [31:0] tx_data_q;
  logic [31:0] tx_msg_q [1:3];
  logic        tx_gnt, tx_valid;
  logic [33:0] tx_flit;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_gnt     = 1'b0;
    tx_valid   = 1'b0;
    tx_flit    = '0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_gnt = bus.core_req_i & bus.core_valid_i;
        if (tx_gnt) tx_state_d = TX_HDR;
      end
      TX_HDR: begin
        tx_valid = 1'b1;
        tx_flit  = {tx_len_q, tx_dest_q, tx_addr_q};
        if (bus.tx_flit_ready_i) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_valid = 1'b1;
        tx_flit  = {2'b00, tx_data_q};
        if (bus.tx_flit_ready_i) tx_state_d = (tx_len_q == 2'd0) ? TX_IDLE : TX_MSG;
      end
      TX_MSG: begin
        tx_valid = 1'b1;
        tx_flit  = {2'b00, tx_msg_q[tx_idx_q]};
        if (bus.tx_flit_ready_i && tx_idx_q == tx_len_q) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_len_q   <= '0;
      tx_idx_q   <= '0;
      tx_dest_q  <= '0;
      tx_addr_q  <= '0;
      tx_data_q  <= '0;
      // NOTE: the message buffer is a handful of flops, not a RAM, so it is
      // reset explicitly to keep stale payload from surviving a reset.
      for (int i = 1; i <= 3; i++) tx_msg_q[i] <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      if (tx_gnt) begin
        tx_len_q    <= bus.core_len_i;
        tx_dest_q   <= bus.core_dest_i;
        tx_addr_q   <= bus.core_addr_i;
        tx_data_q   <= bus.core_data_i;
        tx_msg_q[1] <= bus.core_msg1_i;
        tx_msg_q[2] <= bus.core_msg2_i;
        tx_msg_q[3] <= bus.core_msg3_i;
      end
      // Index of the extra word being sent: 1 after the data flit, then +1.
      if (tx_state_q == TX_DATA && bus.tx_flit_ready_i) tx_idx_q <= 2'd1;
      else if (tx_state_q == TX_MSG && bus.tx_flit_ready_i) tx_idx_q <= tx_idx_q + 2'd1;
    end
  end

  assign bus.core_gnt_o      = tx_gnt;
  assign bus.tx_flit_valid_o = tx_valid;
  assign bus.tx_flit_o       = tx_flit;

  // ---------------------------------------------------------------- RX path
  typedef enum logic [2:0] {R_HDR, R_DATA, R_MSG, R_DROP, R_DELIVER} rx_state_e;

  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_fire, rx_foreign;
  logic [1:0]  rx_len_q, rx_idx_q;
  logic [2:0]  rx_remaining_q;
  logic [15:0] rx_addr_q;
  logic [31:0] rx_data_q;
  logic [31:0] rx_msg_q [1:3];
  logic [7:0]  drop_cnt_q;
  // Last delivered message, shown while no delivery is in progress.
  logic [1:0]  hold_len_q;
  logic [15:0] hold_addr_q;
  logic [31:0] hold_data_q, hold_msg1_q, hold_msg2_q, hold_msg3_q;

  assign rx_fire    = bus.rx_flit_valid_i & (rx_state_q != R_DELIVER);
  assign rx_foreign = DropForeign & (bus.rx_flit_i[31:16] != core_id_i);

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      R_HDR:     if (rx_fire) rx_state_d = rx_foreign ? R_DROP : R_DATA;
      R_DATA:    if (rx_fire) rx_state_d = (rx_len_q == 2'd0) ? R_DELIVER : R_MSG;
      R_MSG:     if (rx_fire && rx_idx_q == rx_len_q) rx_state_d = R_DELIVER;
      R_DROP:    if (rx_fire && rx_remaining_q == 3'd1) rx_state_d = R_HDR;
      R_DELIVER: rx_state_d = R_HDR;
      default:   rx_state_d = R_HDR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q     <= R_HDR;
      rx_len_q       <= '0;
      rx_idx_q       <= '0;
      rx_remaining_q <= '0;
      rx_addr_q      <= '0;
      rx_data_q      <= '0;
      for (int i = 1; i <= 3; i++) rx_msg_q[i] <= '0;
      drop_cnt_q     <= '0;
      hold_len_q     <= '0;
      hold_addr_q    <= '0;
      hold_data_q    <= '0;
      hold_msg1_q    <= '0;
      hold_msg2_q    <= '0;
      hold_msg3_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      unique case (rx_state_q)
        R_HDR: if (rx_fire) begin
          rx_len_q       <= bus.rx_flit_i[33:32];
          rx_addr_q      <= bus.rx_flit_i[15:0];
          rx_idx_q       <= 2'd1;
          // Data flit plus len extra flits remain after the header.
          rx_remaining_q <= {1'b0, bus.rx_flit_i[33:32]} + 3'd1;
          // Words beyond len must read zero on delivery.
          for (int i = 1; i <= 3; i++) rx_msg_q[i] <= '0;
        end
        R_DATA: if (rx_fire) rx_data_q <= bus.rx_flit_i[31:0];
        R_MSG: if (rx_fire) begin
          rx_msg_q[rx_idx_q] <= bus.rx_flit_i[31:0];
          rx_idx_q           <= rx_idx_q + 2'd1;
        end
        R_DROP: if (rx_fire) begin
          rx_remaining_q <= rx_remaining_q - 3'd1;
          if (rx_remaining_q == 3'd1 && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
        R_DELIVER: begin
          hold_len_q  <= rx_len_q;
          hold_addr_q <= rx_addr_q;
          hold_data_q <= rx_data_q;
          hold_msg1_q <= rx_msg_q[1];
          hold_msg2_q <= rx_msg_q[2];
          hold_msg3_q <= rx_msg_q[3];
        end
        default: ;
      endcase
    end
  end

  // During the delivery cycle the freshly assembled message is shown
  // directly; afterwards the hold copy keeps it visible.
  logic delivering;
  assign delivering        = (rx_state_q == R_DELIVER);
  assign bus.deliv_valid_o = delivering;
  assign bus.deliv_len_o   = delivering ? rx_len_q    : hold_len_q;
  assign bus.deliv_addr_o  = delivering ? rx_addr_q   : hold_addr_q;
  assign bus.deliv_data_o  = delivering ? rx_data_q   : hold_data_q;
  assign bus.deliv_msg1_o  = delivering ? rx_msg_q[1] : hold_msg1_q;
  assign bus.deliv_msg2_o  = delivering ? rx_msg_q[2] : hold_msg2_q;
  assign bus.deliv_msg3_o  = delivering ? rx_msg_q[3] : hold_msg3_q;
  assign bus.rx_flit_ready_o = ~delivering;
  assign bus.drop_cnt_o      = drop_cnt_q;

endmodule

// File: doc/ibex_noc_endpoint.md
IBEX_NOC_ENDPOINT -- requirements
Module: ibex_noc_endpoint

Interface
REQ-001 SHALL have parameter DropForeign, default 1'b1: discard received messages whose destination differs from core_id_i.
REQ-002 SHALL have the following ports, one clock and one reset: reset is asynchronous and active-low.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_id_i  in  16  this endpoint's core number (quasi-static)
- core_req_i  in  1  core requests to send a message
- core_gnt_o  out  1  message accepted this cycle
- core_valid_i  in  1  core message fields valid
- core_len_i  in  2  extra word count (0..3)
- core_data_i  in  32  first payload word
- core_addr_i  in  16  destination address
- core_dest_i  in  16  destination core
- core_msg1_i / core_msg2_i / core_msg3_i  in  32 each  extra payload words
- deliv_valid_o  out  1  one-cycle delivery pulse to core
- deliv_len_o  out  2  delivered extra word count
- deliv_data_o  out  32  delivered first word
- deliv_addr_o  out  16  delivered address
- deliv_msg1_o / deliv_msg2_o / deliv_msg3_o  out  32 each  delivered extra words
- tx_flit_valid_o  out  1  outbound flit valid
- tx_flit_ready_i  in  1  network accepts outbound flit
- tx_flit_o  out  34  outbound flit
- rx_flit_valid_i  in  1  inbound flit valid
- rx_flit_ready_o  out  1  endpoint accepts inbound flit
- rx_flit_i  in  34  inbound flit
- drop_cnt_o  out  8  saturating count of discarded messages

Function
REQ-003 Message format SHALL be:
- header flit: [33:32]=len, [31:16]=dest core, [15:0]=addr
- data flit: [31:0]=data
- len flits carrying msg1..msgN, in order
- [33:32]=0 on all non-header flits
- total flits = 2+len
REQ-004 core_gnt_o SHALL equal core_req_i & core_valid_i & (TX state==IDLE), combinationally; on gnt all core_* fields are captured into the TX buffer.
REQ-005 TX FSM SHALL use states IDLE, HDR, DATA, MSG:
- IDLE->HDR on gnt
- HDR->DATA when the header flit is accepted
- DATA->IDLE when the data flit is accepted and len=0; otherwise DATA->MSG
- MSG increments an index 1..len and returns to IDLE when the flit at index len is accepted
REQ-006 TX handshake rules:
- a flit is transferred when tx_flit_valid_o & tx_flit_ready_i
- tx_flit_valid_o is high in HDR, DATA and MSG only
- tx_flit_o is held stable while valid & !ready
REQ-007 First-flit latency SHALL be 1 cycle: tx_flit_valid_o is asserted in the cycle after gnt. A new gnt is possible in the cycle after the final flit is accepted.
REQ-008 RX FSM SHALL use states R_HDR, R_DATA, R_MSG, R_DROP, R_DELIVER:
- R_HDR latches len, dest and addr
- if DropForeign and dest!=core_id_i: go to R_DROP with remaining=1+len
- R_DROP consumes flits until remaining reaches 0, then increments drop_cnt_o (saturating at 255) and returns to R_HDR
- otherwise R_DATA latches data, then R_MSG latches msg words
- after the last flit: R_DELIVER
REQ-009 rx_flit_ready_o SHALL be 1 in every RX state except R_DELIVER.
REQ-010 R_DELIVER SHALL last exactly one cycle:
- deliv_valid_o=1; deliv_* present the assembled message
- msg registers beyond len read 0
- next state R_HDR
- delivery latency: deliv_valid_o is asserted in the cycle after the last flit is accepted
REQ-011 deliv_* outputs SHALL hold their last delivered values while deliv_valid_o=0.
REQ-012 TX and RX paths SHALL be fully independent: simultaneous gnt, tx transfer and rx transfer in one cycle are all honoured.
REQ-013 No backpressure from the core on delivery SHALL exist: the core must consume deliv_valid_o pulses.
REQ-014 A header flit with [33:32] nonzero on a non-header position SHALL be ignored: the field is don't-care outside R_HDR.

Reset
REQ-015 On rst_ni low, asynchronously:
- TX state IDLE, RX state R_HDR, drop_cnt_o=0
- all deliv_* outputs, tx_flit_o and all internal message registers = 0
REQ-016 Reset mid-transfer SHALL abandon partial TX/RX messages with no flit or delivery emitted after reset release until new traffic arrives.

Verification
REQ-017 Send, len=0: core_dest=5, addr=0x0010, data=0xDEADBEEF with ready=1 -> gnt for 1 cycle, then flits {0,0x00050010},{0,0xDEADBEEF} on consecutive cycles, IDLE after.
REQ-018 Send, len=3 with tx_flit_ready_i toggling 1/0 -> 5 flits in order (msg1..3 last); each flit is held stable while ready=0; core_gnt_o stays 0 until the 5th flit is accepted.
REQ-019 Receive, core_id_i=2: flits {1,0x0002_0040},{0,0x11111111},{0,0x22222222} -> deliv_valid_o pulses 1 cycle later with len=1, addr=0x0040, data=0x11111111, msg1=0x22222222, msg2=msg3=0; rx_flit_ready_o=0 during that cycle.
REQ-020 Foreign drop: header with dest=7 (core_id_i=2), len=2 -> 4 flits consumed, no deliv_valid_o, drop_cnt_o 0->1; 300 such messages -> drop_cnt_o=255.
REQ-021 Concurrency and reset: simultaneous send (len=1) and receive (len=0) -> both complete correctly. Reset asserted mid-RX after the header -> deliv_valid_o stays 0; the next full message is delivered correctly.
